// File: rtl/fifo_stream_tx_pkg.sv
// fifo_stream_tx_pkg
//  Shared types and helpers for the FIFO-to-AXI-Stream transmitter.
//  Contents:
//   state_t  transmitter FSM encoding (IDLE / RUN / STOP)
//   clog2()  ceiling log2, used to validate the beat counter width
package fifo_stream_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   // Smallest r with 2**r >= value; value 0 or 1 gives 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((res < 31) && ((32'd1 << res) < value)) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/fifo_stream_tx_if.sv
// fifo_stream_tx_if
//  Bundles the show-ahead FIFO read port and the AXI-Stream master port of
//  the transmitter.
//  Signals:
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO head word (valid while fifo_empty=0)
//   fifo_rd     pop strobe
//   m_tvalid / m_tready / m_tdata / m_tlast   AXI-Stream beat
//  Modports:
//   master  transmitter view (drives fifo_rd and the stream)
//   slave   environment view (FIFO + stream sink)
interface fifo_stream_tx_if #(
   parameter int unsigned DATA_WIDTH = 64
);

   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_rd;
   logic                  m_tvalid;
   logic                  m_tready;
   logic [DATA_WIDTH-1:0] m_tdata;
   logic                  m_tlast;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      input  m_tready,
      output fifo_rd,
      output m_tvalid,
      output m_tdata,
      output m_tlast
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      output m_tready,
      input  fifo_rd,
      input  m_tvalid,
      input  m_tdata,
      input  m_tlast
   );

endinterface

// File: rtl/fifo_stream_tx.sv
// fifo_stream_tx
//  Pops words from a show-ahead FIFO and sends them as an AXI-Stream master,
//  framing every BURST_LEN beats with TLAST. One registered output stage,
//  one beat per cycle, one cycle from pop to m_tdata.
//  Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   en         1 = transmit, 0 = stop at the next frame boundary
//   bus        FIFO read port + AXI-Stream master (fifo_stream_tx_if.master)
//   busy       FSM not in IDLE
//   frame_cnt  frames completed (TLAST handshakes) since reset, wrapping
module fifo_stream_tx
   import fifo_stream_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned BEAT_W     = 3,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   fifo_stream_tx_if.master     bus,
   output logic                 busy,
   output logic [CNT_W-1:0]     frame_cnt
);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   // Parameter sanity checks at elaboration
   if ((BURST_LEN < 2) || (BURST_LEN > 256)) begin : g_bad_burst_len
      $error("fifo_stream_tx: BURST_LEN must be in 2..256");
   end
   if (BEAT_W < clog2(BURST_LEN)) begin : g_bad_beat_w
      $error("fifo_stream_tx: BEAT_W too small for BURST_LEN");
   end

   state_t                  state_q;
   state_t                  state_d;
   logic [BEAT_W-1:0]       beat_cnt;
   logic                    tvalid_q;
   logic                    tlast_q;
   logic [DATA_WIDTH-1:0]   tdata_q;

   logic                    xfer;
   logic                    out_free;
   logic                    at_last;
   logic                    pop_ok;
   logic                    pop;

   // Handshake and pop qualification
   assign xfer     = tvalid_q & bus.m_tready;
   assign out_free = ~tvalid_q | bus.m_tready;
   assign at_last  = (beat_cnt == LAST_BEAT);
   assign pop_ok   = (state_q == ST_RUN) | ((state_q == ST_STOP) & (beat_cnt != '0));
   assign pop      = pop_ok & ~bus.fifo_empty & out_free;

   // Pop strobe is combinational; forced low while reset is held
   assign bus.fifo_rd  = pop & ~reset;
   assign bus.m_tvalid = tvalid_q;
   assign bus.m_tdata  = tdata_q;
   assign bus.m_tlast  = tlast_q;
   assign busy         = (state_q != ST_IDLE);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!en) begin
               // A pop in this cycle opens a frame that must be completed
               if ((beat_cnt != '0) || pop) state_d = ST_STOP;
               else if (out_free)           state_d = ST_IDLE;
            end
         end
         ST_STOP: begin
            if (en)                                 state_d = ST_RUN;
            else if ((beat_cnt == '0) && out_free)  state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, beat counter, output register and frame counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         beat_cnt  <= '0;
         tvalid_q  <= 1'b0;
         tdata_q   <= '0;
         tlast_q   <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (pop) begin
            tdata_q  <= bus.fifo_data;
            tvalid_q <= 1'b1;
            tlast_q  <= at_last;
            beat_cnt <= at_last ? '0 : beat_cnt + BEAT_W'(1);
         end else if (xfer) begin
            tvalid_q <= 1'b0;
         end
         if (xfer && tlast_q) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_stream_tx.sv
// tb_fifo_stream_tx
//  Directed bench for fifo_stream_tx: behavioural show-ahead FIFO on the
//  read side, a beat recorder on the stream side, one task per scenario.
module tb_fifo_stream_tx;

   localparam int unsigned DW = 64;
   localparam int unsigned BL = 8;
   localparam int unsigned BW = 3;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic          busy;
   logic [CW-1:0] frame_cnt;

   fifo_stream_tx_if #(.DATA_WIDTH(DW)) bif ();

   fifo_stream_tx #(
      .DATA_WIDTH (DW),
      .BURST_LEN  (BL),
      .BEAT_W     (BW),
      .CNT_W      (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .bus       (bif),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   // Show-ahead FIFO model
   logic [DW-1:0] mem [0:63];
   int unsigned   wr_ptr = 0;
   int unsigned   rd_ptr = 0;

   assign bif.fifo_empty = (rd_ptr == wr_ptr);
   assign bif.fifo_data  = mem[rd_ptr[5:0]];

   always @(posedge clk) begin
      if (bif.fifo_rd) rd_ptr <= rd_ptr + 1;
   end

   // Stream recorder
   int unsigned   cyc  = 0;
   int unsigned   rx_n = 0;
   logic [DW-1:0] rx_data [0:255];
   logic          rx_last [0:255];
   int unsigned   rx_cyc  [0:255];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && bif.m_tvalid && bif.m_tready) begin
         rx_data[8'(rx_n)] <= bif.m_tdata;
         rx_last[8'(rx_n)] <= bif.m_tlast;
         rx_cyc[8'(rx_n)]  <= cyc;
         rx_n              <= rx_n + 1;
      end
   end

   int passed = 0;
   int total  = 0;

   task automatic push(input logic [DW-1:0] w);
      mem[wr_ptr[5:0]] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset = 1'b1;
      en    = 1'b0;
      bif.m_tready = 1'b1;
      wr_ptr = rd_ptr;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en = 1'b1;
      bif.m_tready = 1'b1;
      push(64'hA0); push(64'hA1); push(64'hA2);
      repeat (3) @(negedge clk);
      total++; if (bif.m_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", bif.m_tvalid); else passed++;
      total++; if (bif.m_tdata !== 64'h0) $display("FAIL rst_tdata: got %h want 0", bif.m_tdata); else passed++;
      total++; if (bif.m_tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", bif.m_tlast); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
      total++; if (frame_cnt !== 16'd0) $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); else passed++;
      total++; if (bif.fifo_rd !== 1'b0) $display("FAIL rst_fifo_rd: got %b want 0", bif.fifo_rd); else passed++;
      reset = 1'b0;
      @(negedge clk);
      total++; if (bif.m_tvalid !== 1'b0) $display("FAIL rst_lat1_tvalid: got %b want 0", bif.m_tvalid); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL rst_lat1_busy: got %b want 1", busy); else passed++;
      @(negedge clk);
      total++; if (bif.m_tvalid !== 1'b1) $display("FAIL rst_lat2_tvalid: got %b want 1", bif.m_tvalid); else passed++;
      total++; if (bif.m_tdata !== 64'hA0) $display("FAIL rst_lat2_tdata: got %h want a0", bif.m_tdata); else passed++;
   endtask

   task automatic test_stream();
      int unsigned base;
      logic [DW:0] got, exp;
      reset_dut();
      for (int i = 0; i < 16; i++) push(DW'(i));
      base = rx_n;
      en = 1'b1;
      for (int k = 0; k < 60 && rx_n < base + 16; k++) @(negedge clk);
      total++; if (rx_n - base !== 16) $display("FAIL stream_count: got %0d want 16", rx_n - base); else passed++;
      en = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL stream_busy: got %b want 0", busy); else passed++;
      total++; if (frame_cnt !== 16'd2) $display("FAIL stream_frame_cnt: got %0d want 2", frame_cnt); else passed++;
      for (int i = 0; i < 16; i++) begin
         got = {rx_last[8'(base + i)], rx_data[8'(base + i)]};
         exp = {1'((i == 7) || (i == 15)), DW'(i)};
         total++; if (got !== exp) $display("FAIL stream_beat%0d: got %h want %h", i, got, exp); else passed++;
         total++;
         if (rx_cyc[8'(base + i)] - rx_cyc[8'(base)] !== i)
            $display("FAIL stream_spacing%0d: got %0d want %0d", i, rx_cyc[8'(base + i)] - rx_cyc[8'(base)], i);
         else passed++;
      end
   endtask

   task automatic test_backpressure();
      int unsigned   base;
      logic [DW-1:0] prev_data;
      logic          prev_stall;
      logic [DW:0]   got, exp;
      reset_dut();
      for (int i = 0; i < 8; i++) push(DW'(64'h30 + i));
      base = rx_n;
      prev_stall = 1'b0;
      prev_data = '0;
      en = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         bif.m_tready = ((k % 2) == 0);
         #1;
         if (prev_stall) begin
            total++;
            if ((bif.m_tvalid !== 1'b1) || (bif.m_tdata !== prev_data))
               $display("FAIL bp_hold: got v=%b d=%h want v=1 d=%h", bif.m_tvalid, bif.m_tdata, prev_data);
            else passed++;
         end
         if (bif.m_tvalid && !bif.m_tready) begin
            total++; if (bif.fifo_rd !== 1'b0) $display("FAIL bp_no_pop: got %b want 0", bif.fifo_rd); else passed++;
         end
         prev_stall = bif.m_tvalid & ~bif.m_tready;
         prev_data  = bif.m_tdata;
      end
      bif.m_tready = 1'b1;
      total++; if (rx_n - base !== 8) $display("FAIL bp_count: got %0d want 8", rx_n - base); else passed++;
      for (int i = 0; i < 8; i++) begin
         got = {rx_last[8'(base + i)], rx_data[8'(base + i)]};
         exp = {1'(i == 7), DW'(64'h30 + i)};
         total++; if (got !== exp) $display("FAIL bp_beat%0d: got %h want %h", i, got, exp); else passed++;
      end
      total++; if (frame_cnt !== 16'd1) $display("FAIL bp_frame_cnt: got %0d want 1", frame_cnt); else passed++;
      en = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL bp_busy: got %b want 0", busy); else passed++;
   endtask

   task automatic test_stop();
      int unsigned base, start_rd, fall_cyc;
      logic [DW:0] got, exp;
      reset_dut();
      for (int i = 0; i < 10; i++) push(DW'(64'h40 + i));
      base = rx_n;
      start_rd = rd_ptr;
      en = 1'b1;
      for (int k = 0; k < 20 && rd_ptr - start_rd < 4; k++) @(negedge clk);
      en = 1'b0;
      for (int k = 0; k < 30 && busy; k++) @(negedge clk);
      fall_cyc = cyc;
      total++; if (busy !== 1'b0) $display("FAIL stop_busy: got %b want 0", busy); else passed++;
      total++; if (rx_n - base !== 8) $display("FAIL stop_count: got %0d want 8", rx_n - base); else passed++;
      for (int i = 0; i < 8; i++) begin
         got = {rx_last[8'(base + i)], rx_data[8'(base + i)]};
         exp = {1'(i == 7), DW'(64'h40 + i)};
         total++; if (got !== exp) $display("FAIL stop_beat%0d: got %h want %h", i, got, exp); else passed++;
      end
      total++;
      if (fall_cyc !== rx_cyc[8'(base + 7)] + 1)
         $display("FAIL stop_busy_timing: got %0d want %0d", fall_cyc, rx_cyc[8'(base + 7)] + 1);
      else passed++;
      total++; if (wr_ptr - rd_ptr !== 2) $display("FAIL stop_fifo_left: got %0d want 2", wr_ptr - rd_ptr); else passed++;
      total++; if (bif.m_tvalid !== 1'b0) $display("FAIL stop_tvalid: got %b want 0", bif.m_tvalid); else passed++;
      total++; if (frame_cnt !== 16'd1) $display("FAIL stop_frame_cnt: got %0d want 1", frame_cnt); else passed++;
   endtask

   task automatic test_empty();
      int unsigned base;
      logic [DW:0] got, exp;
      reset_dut();
      for (int i = 0; i < 6; i++) push(DW'(64'h50 + i));
      base = rx_n;
      en = 1'b1;
      repeat (12) @(negedge clk);
      total++; if (rx_n - base !== 6) $display("FAIL empty_count6: got %0d want 6", rx_n - base); else passed++;
      for (int i = 0; i < 6; i++) begin
         got = {rx_last[8'(base + i)], rx_data[8'(base + i)]};
         exp = {1'b0, DW'(64'h50 + i)};
         total++; if (got !== exp) $display("FAIL empty_beat%0d: got %h want %h", i, got, exp); else passed++;
      end
      total++; if (bif.m_tvalid !== 1'b0) $display("FAIL empty_gap_tvalid: got %b want 0", bif.m_tvalid); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL empty_gap_busy: got %b want 1", busy); else passed++;
      total++; if (frame_cnt !== 16'd0) $display("FAIL empty_gap_frame_cnt: got %0d want 0", frame_cnt); else passed++;
      push(64'h56);
      repeat (3) @(negedge clk);
      push(64'h57);
      repeat (4) @(negedge clk);
      total++; if (rx_n - base !== 8) $display("FAIL empty_count8: got %0d want 8", rx_n - base); else passed++;
      for (int i = 6; i < 8; i++) begin
         got = {rx_last[8'(base + i)], rx_data[8'(base + i)]};
         exp = {1'(i == 7), DW'(64'h50 + i)};
         total++; if (got !== exp) $display("FAIL empty_beat%0d: got %h want %h", i, got, exp); else passed++;
      end
      total++; if (frame_cnt !== 16'd1) $display("FAIL empty_frame_cnt: got %0d want 1", frame_cnt); else passed++;
      en = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL empty_busy: got %b want 0", busy); else passed++;
   endtask

   task automatic test_reset_mid();
      int unsigned base;
      logic [DW:0] got, exp;
      reset_dut();
      bif.m_tready = 1'b0;
      for (int i = 0; i < 12; i++) push(DW'(64'h60 + i));
      base = rx_n;
      en = 1'b1;
      repeat (4) @(negedge clk);
      total++; if (bif.m_tvalid !== 1'b1) $display("FAIL mid_pre_tvalid: got %b want 1", bif.m_tvalid); else passed++;
      total++; if (bif.m_tdata !== 64'h60) $display("FAIL mid_pre_tdata: got %h want 60", bif.m_tdata); else passed++;
      reset = 1'b1;
      @(negedge clk);
      total++; if (bif.m_tvalid !== 1'b0) $display("FAIL mid_rst_tvalid: got %b want 0", bif.m_tvalid); else passed++;
      total++; if (frame_cnt !== 16'd0) $display("FAIL mid_rst_frame_cnt: got %0d want 0", frame_cnt); else passed++;
      total++; if (dut.beat_cnt !== 3'd0) $display("FAIL mid_rst_beat_cnt: got %0d want 0", dut.beat_cnt); else passed++;
      reset = 1'b0;
      bif.m_tready = 1'b1;
      for (int k = 0; k < 40 && rx_n < base + 8; k++) @(negedge clk);
      total++; if (rx_n - base !== 8) $display("FAIL mid_count: got %0d want 8", rx_n - base); else passed++;
      for (int i = 0; i < 8; i++) begin
         got = {rx_last[8'(base + i)], rx_data[8'(base + i)]};
         exp = {1'(i == 7), DW'(64'h61 + i)};
         total++; if (got !== exp) $display("FAIL mid_beat%0d: got %h want %h", i, got, exp); else passed++;
      end
      total++; if (frame_cnt !== 16'd1) $display("FAIL mid_frame_cnt: got %0d want 1", frame_cnt); else passed++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_stop();
      test_empty();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
